// File: rtl/mul_hilo_unit.sv
// Multi-cycle shift-add 32x32 multiplier owning the HI/LO register pair.
// Optional macro MTHILO_EN adds direct HI/LO write ports (mthi/mtlo).
module mul_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MTHILO_EN
    ,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        addend  = '0;
        sum     = '0;

        unique case (state_q)
            StIdle: begin
`ifdef MTHILO_EN
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
`endif
                if (start) begin
                    // Magnitude of the most-negative value wraps to itself, read as unsigned.
                    mag_a_d = (sgn && a[WIDTH-1]) ? -a : a;
                    mag_b_d = (sgn && b[WIDTH-1]) ? -b : b;
                    neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                addend  = mag_b_q[0] ? mag_a_q : '0;
                sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed, table-driven bench for mul_hilo_unit plus protocol and reset sequences.
module tb_mul_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MTHILO_EN
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
`endif

    mul_hilo_unit #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sgn  (sgn),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
`ifdef MTHILO_EN
        ,
        .wr_hi(wr_hi),
        .wr_lo(wr_lo),
        .wdata(wdata)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; raises start, then follows the run until done (bounded).
    // inject >= 0 pulses a spurious start (a=1,b=1) at that cycle of the run.
    task automatic run_mul(input logic s, input logic [31:0] x, input logic [31:0] y,
                           input int inject, input logic [63:0] product);
        int lat;
        int busy_bad;
        int hold_bad;
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start    = 1'b0;
        sgn      = ~s;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        busy_bad = 0;
        hold_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (hi !== exp_hi || lo !== exp_lo) hold_bad++;
            if (lat == inject) begin
                start = 1'b1;
                sgn   = 1'b0;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'd33);
        chk("busy_during_run", 64'(busy_bad), 64'd0);
        chk("hilo_hold", 64'(hold_bad), 64'd0);
        chk("busy_with_done", {63'd0, busy}, 64'd0);
        chk("hi", {32'd0, hi}, {32'd0, product[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, product[31:0]});
        exp_hi = product[63:32];
        exp_lo = product[31:0];
    endtask

    initial begin
        int done_cnt;
        int nz_cnt;

        vecs[0] = '{1'b0, 32'd7,         32'd6,         64'h00000000_0000002A};
        vecs[1] = '{1'b1, 32'hFFFFFFFD,  32'd5,         64'hFFFFFFFF_FFFFFFF1};
        vecs[2] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[3] = '{1'b1, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
        vecs[4] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001};
        vecs[5] = '{1'b0, 32'h80000000,  32'd2,         64'h00000001_00000000};
        vecs[6] = '{1'b1, 32'h7FFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF_80000001};
        vecs[7] = '{1'b0, 32'd0,         32'd5,         64'h00000000_00000000};
        vecs[8] = '{1'b1, 32'h80000000,  32'd1,         64'hFFFFFFFF_80000000};
        vecs[9] = '{1'b0, 32'h12345678,  32'h10,        64'h00000001_23456780};

        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_done", {63'd0, done}, 64'd0);

        // Back-to-back: every start after the first lands in the done cycle.
        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].s, vecs[i].a, vecs[i].b, -1, vecs[i].p);
        end

        // Spurious start mid-run must be ignored.
        run_mul(1'b0, 32'd7, 32'd6, 10, 64'h00000000_0000002A);

        // Idle gap, then a done pulse must not repeat.
        @(posedge clk);
        #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        run_mul(1'b1, 32'hFFFFFFFD, 32'd5, -1, 64'hFFFFFFFF_FFFFFFF1);

        // Asynchronous reset during RUN.
        start = 1'b1;
        sgn   = 1'b0;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        nz_cnt   = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) nz_cnt++;
        end
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk("rst_stays_idle", 64'(nz_cnt), 64'd0);
        exp_hi = '0;
        exp_lo = '0;

`ifdef MTHILO_EN
        wr_hi = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        chk("mthi_idle", {32'd0, hi}, 64'h12345678);
        start = 1'b1;
        sgn   = 1'b0;
        a     = 32'd7;
        b     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        chk("mthi_busy_ignored", {32'd0, hi}, 64'h12345678);
        done_cnt = 0;
        while (done !== 1'b1 && done_cnt < 40) begin
            @(posedge clk);
            #1;
            done_cnt++;
        end
        chk("mthi_commit", {hi, lo}, 64'h00000000_0000002A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
